// File: rtl/cpu6502_pkg.sv
// rtl/cpu6502_pkg.sv - shared CPU widths, prefetch FSM states and instruction lengths
package cpu6502_pkg;

   localparam int AW_DEFAULT = 16;
   localparam int BYTE_W = 8;
   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_REQ,
      PF_DRAIN
   } pf_state_t;

   // Instruction lengths, shared with the addressing-mode decoder
   localparam logic [1:0] LEN1 = 2'd1;
   localparam logic [1:0] LEN2 = 2'd2;
   localparam logic [1:0] LEN3 = 2'd3;

   // A pop is legal when it consumes 1..3 bytes that are actually present
   function automatic logic pop_len_ok(input logic [1:0] len, input logic [6:0] avail);
      return (len >= LEN1) && (len <= LEN3) && ({5'd0, len} <= avail);
   endfunction

endpackage

// File: rtl/byte_ring.sv
// rtl/byte_ring.sv - circular byte store with 3-byte head peek and 1..3 byte pop
module byte_ring
   import cpu6502_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic [BYTE_W-1:0] push_data,
   input  logic              pop,
   input  logic [1:0]        pop_len,
   output logic [CW-1:0]     count,
   output logic [BYTE_W-1:0] byte0,
   output logic [BYTE_W-1:0] byte1,
   output logic [BYTE_W-1:0] byte2
);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     pop_amt;

   assign pop_amt = pop ? CW'(pop_len) : '0;

   // Push and pop may coincide on a full ring: the pop frees the slot being written
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(pop_len);
         end
         count <= count + CW'(push) - pop_amt;
      end
   end

   assign byte0 = mem[head];
   assign byte1 = mem[head + PW'(1)];
   assign byte2 = mem[head + PW'(2)];

endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction byte prefetcher feeding the decoder queue
// Optional PREFETCH_BYPASS_EN: an ack into an empty queue is visible at q_byte0 the same cycle.
module inst_prefetch
   import cpu6502_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW = AW_DEFAULT,
   parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [AW-1:0]     flush_pc,
   output logic              mem_req,
   output logic [AW-1:0]     mem_addr,
   input  logic              mem_ack,
   input  logic [BYTE_W-1:0] mem_rdata,
   output logic [CW-1:0]     q_count,
   output logic [BYTE_W-1:0] q_byte0,
   output logic [BYTE_W-1:0] q_byte1,
   output logic [BYTE_W-1:0] q_byte2,
   output logic [AW-1:0]     q_pc,
   input  logic              q_pop,
   input  logic [1:0]        q_pop_len,
   output logic              pop_err
);

   pf_state_t         state;
   pf_state_t         state_nxt;
   logic [AW-1:0]     fetch_addr;
   logic [AW-1:0]     drain_addr;
   logic [AW-1:0]     pc_r;
   logic              pop_err_r;
   logic [CW-1:0]     ring_count;
   logic [CW-1:0]     cnt_next;
   logic [BYTE_W-1:0] rb0;
   logic [BYTE_W-1:0] rb1;
   logic [BYTE_W-1:0] rb2;
   logic              ack_valid;
   logic              push_ok;
   logic              bypass;
   logic              len_ok;
   logic              pop_ok;
   logic              pop_bad;
   logic              bypass_pop;
   logic              ring_push;
   logic              ring_pop;

   // An ack only counts while our request is on the bus
   assign ack_valid = mem_ack && (state != PF_IDLE);
   assign push_ok   = ack_valid && (state == PF_REQ) && !flush;

`ifdef PREFETCH_BYPASS_EN
   assign bypass = push_ok && (ring_count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign q_count    = bypass ? CW'(1) : ring_count;
   assign len_ok     = pop_len_ok(q_pop_len, 7'(q_count));
   assign pop_ok     = q_pop && !flush && len_ok;
   assign pop_bad    = q_pop && !flush && !len_ok;
   assign bypass_pop = bypass && pop_ok;
   assign ring_push  = push_ok && !bypass_pop;
   assign ring_pop   = pop_ok && !bypass_pop;
   assign cnt_next   = ring_count + CW'(ring_push) - (ring_pop ? CW'(q_pop_len) : '0);

   byte_ring #(.DEPTH(DEPTH)) u_ring (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (ring_push),
      .push_data (mem_rdata),
      .pop       (ring_pop),
      .pop_len   (q_pop_len),
      .count     (ring_count),
      .byte0     (rb0),
      .byte1     (rb1),
      .byte2     (rb2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PF_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         PF_IDLE: begin
            if (flush || (cnt_next < CW'(DEPTH))) begin
               state_nxt = PF_REQ;
            end
         end
         PF_REQ: begin
            if (flush) begin
               state_nxt = ack_valid ? PF_REQ : PF_DRAIN;
            end else if (ack_valid && (cnt_next >= CW'(DEPTH))) begin
               state_nxt = PF_IDLE;
            end
         end
         PF_DRAIN: begin
            if (ack_valid) begin
               state_nxt = PF_REQ;
            end
         end
         default: state_nxt = PF_IDLE;
      endcase
   end

   // DRAIN keeps presenting the abandoned address until its ack retires it
   always_comb begin
      mem_req  = (state != PF_IDLE);
      mem_addr = (state == PF_DRAIN) ? drain_addr : fetch_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_addr <= RESET_PC;
         drain_addr <= RESET_PC;
         pc_r       <= RESET_PC;
         pop_err_r  <= 1'b0;
      end else begin
         if (flush) begin
            fetch_addr <= flush_pc;
            pc_r       <= flush_pc;
            if ((state == PF_REQ) && !ack_valid) begin
               drain_addr <= fetch_addr;
            end
         end else begin
            if (push_ok) begin
               fetch_addr <= fetch_addr + AW'(1);
            end
            if (pop_ok) begin
               pc_r <= pc_r + AW'(q_pop_len);
            end
         end
         if (pop_bad) begin
            pop_err_r <= 1'b1;
         end
      end
   end

   assign q_byte0 = bypass ? mem_rdata : rb0;
   assign q_byte1 = rb1;
   assign q_byte2 = rb2;
   assign q_pc    = pc_r;
   assign pop_err = pop_err_r;

endmodule

// File: tb/tb_inst_prefetch.sv
// tb/tb_inst_prefetch.sv - directed and randomized checks of inst_prefetch against a queue model
module tb_inst_prefetch;

   localparam int DEPTH = 16;
   localparam logic [15:0] RPC = 16'hC000;
`ifdef PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        flush;
   logic [15:0] flush_pc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [4:0]  q_count;
   logic [7:0]  q_byte0;
   logic [7:0]  q_byte1;
   logic [7:0]  q_byte2;
   logic [15:0] q_pc;
   logic        q_pop;
   logic [1:0]  q_pop_len;
   logic        pop_err;

   inst_prefetch #(.DEPTH(DEPTH), .AW(16), .RESET_PC(RPC)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .flush_pc  (flush_pc),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .q_count   (q_count),
      .q_byte0   (q_byte0),
      .q_byte1   (q_byte1),
      .q_byte2   (q_byte2),
      .q_pc      (q_pc),
      .q_pop     (q_pop),
      .q_pop_len (q_pop_len),
      .pop_err   (pop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: memory returns addr[7:0]; queue holds fetched bytes in order
   logic [7:0]  mq[$];
   logic [15:0] m_pc;
   logic [15:0] exp_addr;
   logic [15:0] drain_addr;
   bit          drain;
   bit          m_err;
   int          streak;

   logic        s_req;
   int          s_count;
   logic [7:0]  s_b0;
   logic [7:0]  s_b1;
   logic [7:0]  s_b2;
   logic [15:0] s_addr;
   logic [15:0] s_pc;
   logic        s_err;

   logic        r_fl;
   logic [15:0] r_fpc;
   logic        r_pop;
   logic [1:0]  r_len;
   logic        r_ack;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      flush     = 1'b0;
      q_pop     = 1'b0;
      q_pop_len = 2'd0;
      mem_ack   = 1'($urandom % 2);
      mem_rdata = 8'hEE;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      mem_ack = 1'b0;
      mq.delete();
      m_pc       = RPC;
      exp_addr   = RPC;
      drain_addr = RPC;
      drain      = 1'b0;
      m_err      = 1'b0;
      streak     = 0;
      check_eq("rst_count", q_count, 0);
      check_eq("rst_req", mem_req, 0);
      check_eq("rst_err", pop_err, 0);
      check_eq("rst_pc", q_pc, RPC);
      check_eq("rst_b0", q_byte0, 0);
      check_eq("rst_b1", q_byte1, 0);
      check_eq("rst_b2", q_byte2, 0);
   endtask

   // One clock: drive at edge+1, check at edge+5, advance the model across the next edge
   task automatic step(input logic fl, input logic [15:0] fpc, input logic pop,
                       input logic [1:0] len, input logic ack);
      logic [15:0] raddr;
      logic        ackv;
      logic        byp;
      logic        legal;
      logic        nd;
      int          cv;
      raddr     = drain ? drain_addr : exp_addr;
      flush     = fl;
      flush_pc  = fpc;
      q_pop     = pop;
      q_pop_len = len;
      mem_ack   = ack;
      mem_rdata = raddr[7:0];
      #4;
      s_req   = mem_req;
      s_count = int'(q_count);
      s_b0    = q_byte0;
      s_b1    = q_byte1;
      s_b2    = q_byte2;
      s_addr  = mem_addr;
      s_pc    = q_pc;
      s_err   = pop_err;

      ackv = ack && s_req;
      byp  = BYP && ackv && !fl && !drain && (mq.size() == 0);
      cv   = mq.size() + int'(byp);
      check_eq("q_count", q_count, cv);
      if (cv >= 1) check_eq("q_byte0", q_byte0, byp ? raddr[7:0] : mq[0]);
      if (cv >= 2) check_eq("q_byte1", q_byte1, mq[1]);
      if (cv >= 3) check_eq("q_byte2", q_byte2, mq[2]);
      check_eq("q_pc", q_pc, m_pc);
      check_eq("pop_err", pop_err, m_err);
      if (s_req) check_eq("mem_addr", mem_addr, raddr);
      if (drain) check_eq("drain_req", mem_req, 1);
      if (mq.size() == DEPTH) check_eq("full_no_req", mem_req, 0);
      if (!s_req && (mq.size() < DEPTH)) streak++;
      else streak = 0;
      check_eq("req_live", streak <= 1, 1);

      legal = pop && (len != 2'd0) && (int'(len) <= cv);
      if (fl) begin
         nd = s_req && !ack;
         if (nd && !drain) drain_addr = exp_addr;
         drain    = nd;
         exp_addr = fpc;
         m_pc     = fpc;
         mq.delete();
      end else begin
         if (pop && !legal) m_err = 1'b1;
         if (ackv) begin
            if (drain) begin
               drain = 1'b0;
            end else begin
               mq.push_back(exp_addr[7:0]);
               exp_addr = exp_addr + 16'd1;
            end
         end
         if (legal) begin
            for (int i = 0; i < int'(len); i++) void'(mq.pop_front());
            m_pc = m_pc + 16'(len);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      flush_pc  = 16'h0000;
      q_pop     = 1'b0;
      q_pop_len = 2'd0;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      @(posedge clk);
      do_reset();

      // Fill from RESET_PC with an ack every cycle
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      check_eq("idle_after_reset", s_req, 0);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      check_eq("first_req", s_req, 1);
      check_eq("first_addr", s_addr, 16'hC000);
      repeat (20) step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      check_eq("fill_count", s_count, 16);
      check_eq("fill_req", s_req, 0);
      check_eq("fill_b0", s_b0, 8'h00);
      check_eq("fill_b1", s_b1, 8'h01);
      check_eq("fill_b2", s_b2, 8'h02);
      check_eq("fill_pc", s_pc, 16'hC000);

      // Full queue, 3-byte pops with continuous acks
      repeat (30) step(1'b0, 16'h0, mq.size() >= 3, 2'd3, 1'b1);

      // Flush while the C005 request is pending; ack arrives three cycles later
      do_reset();
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      repeat (5) step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      check_eq("pend_addr", s_addr, 16'hC005);
      step(1'b1, 16'h8000, 1'b0, 2'd0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      check_eq("drain_addr", s_addr, 16'hC005);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      check_eq("drain_ack_addr", s_addr, 16'hC005);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      check_eq("redirect_addr", s_addr, 16'h8000);
      check_eq("redirect_count", s_count, 0);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      check_eq("redirect_fill", s_count, 1);
      check_eq("redirect_b0", s_b0, 8'h00);

      // Address wrap from FFFE
      step(1'b1, 16'hFFFE, 1'b0, 2'd0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      check_eq("wrap_a0", s_addr, 16'hFFFE);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      check_eq("wrap_a1", s_addr, 16'hFFFF);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      check_eq("wrap_a2", s_addr, 16'h0000);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      check_eq("wrap_a3", s_addr, 16'h0001);
      step(1'b0, 16'h0, 1'b1, 2'd3, 1'b0);
      check_eq("wrap_pc_before", s_pc, 16'hFFFE);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      check_eq("wrap_pc_after", s_pc, 16'h0001);

      // Illegal pop with one byte present, then sticky error
      do_reset();
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      check_eq("perr_count", s_count, 1);
      step(1'b0, 16'h0, 1'b1, 2'd2, 1'b0);
      step(1'b0, 16'h0, 1'b1, 2'd1, 1'b0);
      check_eq("perr_set", s_err, 1);
      check_eq("perr_nochange", s_count, 1);
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      check_eq("perr_sticky", s_err, 1);
      check_eq("perr_legal_pop", s_count, 0);

      // Ack into an empty queue with a same-cycle 1-byte pop
      do_reset();
      step(1'b1, 16'h12A9, 1'b0, 2'd0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 2'd1, 1'b1);
      if (BYP) begin
         check_eq("byp_b0", s_b0, 8'hA9);
         check_eq("byp_count", s_count, 1);
      end else begin
         check_eq("nobyp_count", s_count, 0);
      end
      step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
      if (BYP) begin
         check_eq("byp_after_count", s_count, 0);
         check_eq("byp_after_err", s_err, 0);
      end else begin
         check_eq("nobyp_after_count", s_count, 1);
         check_eq("nobyp_after_b0", s_b0, 8'hA9);
         check_eq("nobyp_after_err", s_err, 1);
      end

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ((c % 600) == 0) do_reset();
         r_fl  = ($urandom_range(0, 39) == 0);
         r_fpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                             : 16'($urandom);
         r_len = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 49) == 0) r_len = 2'($urandom_range(0, 3));
         r_pop = ($urandom % 2 == 1) &&
                 ((int'(r_len) <= mq.size()) || ($urandom_range(0, 49) == 0));
         r_ack = ($urandom % 4 != 0);
         step(r_fl, r_fpc, r_pop, r_len, r_ack);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
